ghost_collision_ctrl: RTL and testbench

- Game-state controller sitting directly upstream of the colour mapper.
- Watches the per-pixel sprite-hit flags during each VGA frame and decides, at frame boundaries, whether Pac-Man touched a ghost.
- Runs the PLAY/HIT/OVER state machine.
- Drives is_collision_red/green/blue to the colour mapper (game-over text colouring) and freeze to the motion blocks.

---
 rtl/ghost_collision_ctrl.sv | 177 +++++++++++++++++
 tb/tb_ghost_collision_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/ghost_collision_ctrl.sv
// Ghost collision / game-state controller.
// Counts Pac-Man/ghost overlap pixels per VGA frame and decides at each frame
// boundary whether a collision occurred, running the PLAY/HIT/OVER game FSM.
// Optional macro GHOST_COLLISION_LIVES_EN enables multi-life play; without it
// the first collision always ends the game and lives reads as 0.
module ghost_collision_ctrl #(
  parameter int PLAYFIELD_H   = 352,
  parameter int HIT_THRESHOLD = 4,
  parameter int HIT_FRAMES    = 60,
  parameter int START_LIVES   = 3
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic       pixel_valid,
  input  logic [9:0] DrawX,
  input  logic [9:0] DrawY,
  input  logic       is_ball,
  input  logic       is_red_evil,
  input  logic       is_green_evil,
  input  logic       is_blue_evil,
  input  logic       restart,
  output logic       is_collision_red,
  output logic       is_collision_green,
  output logic       is_collision_blue,
  output logic       freeze,
  output logic       game_over,
  output logic [1:0] lives
);

  typedef enum logic [1:0] {PLAY, HIT, OVER} state_t;

`ifdef GHOST_COLLISION_LIVES_EN
  localparam logic [1:0] LIVES_INIT = 2'(START_LIVES);
`else
  localparam logic [1:0] LIVES_INIT = 2'd0;
`endif

  logic       fsync1, fsync2, fsync3, frame_tick;
  logic       restart_d, restart_edge;
  state_t     state, state_n;
  logic [1:0] lives_q, lives_n;
  logic [2:0] col_q, col_n;
  logic [7:0] frame_cnt, frame_cnt_n;
  logic       freeze_q, freeze_n, game_over_q, game_over_n;
  logic [7:0] cnt_r, cnt_g, cnt_b;
  logic       ov_r, ov_g, ov_b;
  logic       hit_r, hit_g, hit_b, any_hit;
  logic       unused_ok;

  // DrawX is only of debug interest; START_LIVES is ignored in single-life builds
  assign unused_ok = ^{DrawX, 2'(START_LIVES)};

  assign restart_edge = restart & ~restart_d;

  assign ov_r = pixel_valid & is_ball & is_red_evil   & (DrawY < 10'(PLAYFIELD_H));
  assign ov_g = pixel_valid & is_ball & is_green_evil & (DrawY < 10'(PLAYFIELD_H));
  assign ov_b = pixel_valid & is_ball & is_blue_evil  & (DrawY < 10'(PLAYFIELD_H));

  assign hit_r   = cnt_r >= 8'(HIT_THRESHOLD);
  assign hit_g   = cnt_g >= 8'(HIT_THRESHOLD);
  assign hit_b   = cnt_b >= 8'(HIT_THRESHOLD);
  assign any_hit = hit_r | hit_g | hit_b;

  // Synchronise VGA_VS into the Clk domain and make a one-cycle tick on its rising edge
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      fsync1     <= 1'b0;
      fsync2     <= 1'b0;
      fsync3     <= 1'b0;
      frame_tick <= 1'b0;
      restart_d  <= 1'b0;
    end else begin
      fsync1     <= frame_clk;
      fsync2     <= fsync1;
      fsync3     <= fsync2;
      frame_tick <= fsync2 & ~fsync3;
      restart_d  <= restart;
    end
  end

  // Saturating per-ghost overlap counters, cleared each frame and idle outside PLAY
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      cnt_r <= 8'd0;
      cnt_g <= 8'd0;
      cnt_b <= 8'd0;
    end else if (restart_edge || frame_tick || state != PLAY) begin
      cnt_r <= 8'd0;
      cnt_g <= 8'd0;
      cnt_b <= 8'd0;
    end else begin
      if (ov_r && cnt_r != 8'hFF) cnt_r <= cnt_r + 8'd1;
      if (ov_g && cnt_g != 8'hFF) cnt_g <= cnt_g + 8'd1;
      if (ov_b && cnt_b != 8'hFF) cnt_b <= cnt_b + 8'd1;
    end
  end

  // Game state register together with its registered outputs
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state       <= PLAY;
      lives_q     <= LIVES_INIT;
      col_q       <= 3'b000;
      frame_cnt   <= 8'd0;
      freeze_q    <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      state       <= state_n;
      lives_q     <= lives_n;
      col_q       <= col_n;
      frame_cnt   <= frame_cnt_n;
      freeze_q    <= freeze_n;
      game_over_q <= game_over_n;
    end
  end

  // Next-state logic: restart wins, otherwise decisions happen only on frame ticks
  always_comb begin
    state_n     = state;
    lives_n     = lives_q;
    col_n       = col_q;
    frame_cnt_n = frame_cnt;
    if (restart_edge) begin
      state_n     = PLAY;
      lives_n     = LIVES_INIT;
      col_n       = 3'b000;
      frame_cnt_n = 8'd0;
    end else if (frame_tick) begin
      case (state)
        PLAY: begin
          if (any_hit) begin
            col_n       = {hit_r, hit_g, hit_b};
            frame_cnt_n = 8'(HIT_FRAMES);
            state_n     = HIT;
`ifdef GHOST_COLLISION_LIVES_EN
            lives_n     = (lives_q != 2'd0) ? lives_q - 2'd1 : 2'd0;
`endif
          end
        end
        HIT: begin
          if (frame_cnt <= 8'd1) begin
            frame_cnt_n = 8'd0;
`ifdef GHOST_COLLISION_LIVES_EN
            if (lives_q == 2'd0) begin
              state_n = OVER;
            end else begin
              col_n   = 3'b000;
              state_n = PLAY;
            end
`else
            state_n = OVER;
`endif
          end else begin
            frame_cnt_n = frame_cnt - 8'd1;
          end
        end
        OVER: begin
          state_n = OVER;
        end
        default: begin
          state_n = PLAY;
        end
      endcase
    end
    freeze_n    = (state_n != PLAY);
    game_over_n = (state_n == OVER);
  end

  assign is_collision_red   = col_q[2];
  assign is_collision_green = col_q[1];
  assign is_collision_blue  = col_q[0];
  assign freeze             = freeze_q;
  assign game_over          = game_over_q;
  assign lives              = lives_q;

endmodule

// File: tb/tb_ghost_collision_ctrl.sv
// Directed self-checking bench for ghost_collision_ctrl.
// Expected lives follow GHOST_COLLISION_LIVES_EN (0 when the macro is undefined).
module tb_ghost_collision_ctrl;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       frame_clk;
  logic       pixel_valid;
  logic [9:0] DrawX;
  logic [9:0] DrawY;
  logic       is_ball;
  logic       is_red_evil;
  logic       is_green_evil;
  logic       is_blue_evil;
  logic       restart;
  logic       is_collision_red;
  logic       is_collision_green;
  logic       is_collision_blue;
  logic       freeze;
  logic       game_over;
  logic [1:0] lives;

  int total = 0;
  int bad   = 0;

  ghost_collision_ctrl dut (
    .Clk                (Clk),
    .Reset              (Reset),
    .frame_clk          (frame_clk),
    .pixel_valid        (pixel_valid),
    .DrawX              (DrawX),
    .DrawY              (DrawY),
    .is_ball            (is_ball),
    .is_red_evil        (is_red_evil),
    .is_green_evil      (is_green_evil),
    .is_blue_evil       (is_blue_evil),
    .restart            (restart),
    .is_collision_red   (is_collision_red),
    .is_collision_green (is_collision_green),
    .is_collision_blue  (is_collision_blue),
    .freeze             (freeze),
    .game_over          (game_over),
    .lives              (lives)
  );

  // 50 MHz system clock
  always #10 Clk = ~Clk;

  // Expected output vector {red, green, blue, freeze, game_over, lives}
  function automatic logic [6:0] ex(input logic r, input logic g, input logic b,
                                    input logic fr, input logic go, input int lv);
    logic [1:0] l;
`ifdef GHOST_COLLISION_LIVES_EN
    l = 2'(lv);
`else
    l = 2'd0 & 2'(lv);
`endif
    return {r, g, b, fr, go, l};
  endfunction

  task automatic checkOutput(input string tag, input logic [6:0] expv);
    logic [6:0] obs;
    obs = {is_collision_red, is_collision_green, is_collision_blue, freeze, game_over, lives};
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, expv);
    end
  endtask

  // Drive n cycles of Pac-Man pixels overlapping the selected ghosts
  task automatic applyStimulus(input int n, input logic r, input logic g, input logic b,
                               input logic [9:0] y, input logic pv);
    for (int i = 0; i < n; i++) begin
      @(negedge Clk);
      is_ball       = 1'b1;
      is_red_evil   = r;
      is_green_evil = g;
      is_blue_evil  = b;
      DrawY         = y;
      DrawX         = 10'(i % 640);
      pixel_valid   = pv;
    end
    @(negedge Clk);
    is_ball       = 1'b0;
    is_red_evil   = 1'b0;
    is_green_evil = 1'b0;
    is_blue_evil  = 1'b0;
    pixel_valid   = 1'b0;
  endtask

  task automatic frame();
    @(negedge Clk);
    frame_clk = 1'b1;
    repeat (6) @(negedge Clk);
    frame_clk = 1'b0;
    repeat (4) @(negedge Clk);
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) frame();
  endtask

  task automatic pulseRestart();
    @(negedge Clk);
    restart = 1'b1;
    repeat (2) @(negedge Clk);
    restart = 1'b0;
    repeat (2) @(negedge Clk);
  endtask

  // Directed test sequence
  initial begin
    Reset = 1'b1; frame_clk = 1'b0; pixel_valid = 1'b0; DrawX = '0; DrawY = '0;
    is_ball = 1'b0; is_red_evil = 1'b0; is_green_evil = 1'b0; is_blue_evil = 1'b0;
    restart = 1'b0;
    repeat (3) @(negedge Clk);
    checkOutput("reset_state", ex(0, 0, 0, 0, 0, 3));
    Reset = 1'b0;

    for (int f = 0; f < 3; f++) begin
      applyStimulus(3, 1, 0, 0, 10'd100, 1);
      frame();
      checkOutput("below_threshold", ex(0, 0, 0, 0, 0, 3));
    end

    applyStimulus(4, 1, 0, 0, 10'd100, 1);
    frame();
    checkOutput("red_hit", ex(1, 0, 0, 1, 0, 2));
    frames(59);
    checkOutput("hit_hold_59", ex(1, 0, 0, 1, 0, 2));
    frame();
`ifdef GHOST_COLLISION_LIVES_EN
    checkOutput("hit_expire", ex(0, 0, 0, 0, 0, 2));
`else
    checkOutput("hit_expire_over", ex(1, 0, 0, 1, 1, 0));
`endif
    pulseRestart();
    checkOutput("restart_1", ex(0, 0, 0, 0, 0, 3));

    applyStimulus(10, 0, 1, 0, 10'd200, 1);
    applyStimulus(5, 0, 0, 1, 10'd200, 1);
    frame();
    checkOutput("green_blue_hit", ex(0, 1, 1, 1, 0, 2));
    frames(60);
`ifdef GHOST_COLLISION_LIVES_EN
    checkOutput("gb_expire", ex(0, 0, 0, 0, 0, 2));
`else
    checkOutput("gb_expire_over", ex(0, 1, 1, 1, 1, 0));
`endif
    pulseRestart();
    checkOutput("restart_2", ex(0, 0, 0, 0, 0, 3));

    applyStimulus(50, 1, 1, 1, 10'd360, 1);
    applyStimulus(50, 1, 1, 1, 10'd100, 0);
    applyStimulus(4, 1, 0, 0, 10'd352, 1);
    frame();
    checkOutput("masked_no_hit", ex(0, 0, 0, 0, 0, 3));

    applyStimulus(4, 0, 0, 1, 10'd351, 1);
    frame();
    checkOutput("last_row_hit", ex(0, 0, 1, 1, 0, 2));
    frames(60);
    pulseRestart();
    checkOutput("restart_3", ex(0, 0, 0, 0, 0, 3));

    applyStimulus(258, 1, 0, 0, 10'd50, 1);
    frame();
    checkOutput("saturate_hit", ex(1, 0, 0, 1, 0, 2));
    frames(60);
    pulseRestart();
    checkOutput("restart_4", ex(0, 0, 0, 0, 0, 3));

`ifdef GHOST_COLLISION_LIVES_EN
    for (int h = 0; h < 3; h++) begin
      applyStimulus(4, 1, 0, 0, 10'd100, 1);
      frame();
      checkOutput("multi_hit_enter", ex(1, 0, 0, 1, 0, 2 - h));
      frames(60);
      if (h < 2) checkOutput("multi_hit_exit", ex(0, 0, 0, 0, 0, 2 - h));
    end
    checkOutput("game_over", ex(1, 0, 0, 1, 1, 0));
`else
    applyStimulus(4, 1, 0, 0, 10'd100, 1);
    frame();
    checkOutput("single_hit_enter", ex(1, 0, 0, 1, 0, 0));
    frames(60);
    checkOutput("game_over", ex(1, 0, 0, 1, 1, 0));
`endif
    applyStimulus(20, 0, 1, 0, 10'd100, 1);
    frame();
    checkOutput("over_holds", ex(1, 0, 0, 1, 1, 0));
    pulseRestart();
    checkOutput("restart_from_over", ex(0, 0, 0, 0, 0, 3));

    applyStimulus(300, 1, 0, 0, 10'd100, 1);
    @(negedge Clk);
    frame_clk = 1'b1;
    repeat (3) @(negedge Clk);
    restart = 1'b1;
    repeat (3) @(negedge Clk);
    frame_clk = 1'b0;
    restart = 1'b0;
    repeat (4) @(negedge Clk);
    checkOutput("restart_vs_tick", ex(0, 0, 0, 0, 0, 3));
    frame();
    checkOutput("restart_vs_tick_next", ex(0, 0, 0, 0, 0, 3));

    applyStimulus(6, 0, 1, 0, 10'd100, 1);
    frame();
    checkOutput("pre_async_reset", ex(0, 1, 0, 1, 0, 2));
    @(negedge Clk);
    #2 Reset = 1'b1;
    #1 checkOutput("async_reset", ex(0, 0, 0, 0, 0, 3));
    @(negedge Clk);
    Reset = 1'b0;
    frame();
    checkOutput("after_reset_frame", ex(0, 0, 0, 0, 0, 3));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
